// File: rtl/log_page_assembler.sv
`default_nettype none
// ============================================================================
// Module   : log_page_assembler
// Purpose  : Packs a log byte stream into PAGES_PER_WRITE page-RAM slots and
//            requests a flash write per full (or flushed and padded) batch.
//            Optional macro LOG_PAGE_SEQ_HDR_EN prefixes each batch with a
//            4-byte big-endian batch sequence header.
// Revision : 1.0
// ============================================================================
module log_page_assembler #(
    parameter int         PAGE_BYTES      = 8192,
    parameter int         PAGES_PER_WRITE = 3,
    parameter logic [7:0] PAD_BYTE        = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush_req,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        en_write,
    input  logic        end_write,
    output logic        busy,
    output logic [15:0] batch_cnt
);

    typedef enum logic [2:0] {
        S_FILL = 3'd0,
        S_HDR  = 3'd1,
        S_PAD  = 3'd2,
        S_REQ  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    localparam logic [12:0] LAST_OFF  = 13'(PAGE_BYTES - 1);
    localparam logic [1:0]  LAST_SLOT = 2'(PAGES_PER_WRITE - 1);

`ifdef LOG_PAGE_SEQ_HDR_EN
    localparam state_t      BATCH_START = S_HDR;
    localparam logic [12:0] FIRST_OFF   = 13'd4;
`else
    localparam state_t      BATCH_START = S_FILL;
    localparam logic [12:0] FIRST_OFF   = 13'd0;
`endif

    state_t      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [12:0] offset_q, offset_d;
    logic        in_ready_q, in_ready_d;
    logic        ram_we_q, ram_we_d;
    logic [14:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        en_write_q, en_write_d;
    logic        busy_q, busy_d;
    logic [15:0] batch_cnt_q, batch_cnt_d;

    logic accept;
    logic at_last_byte;
    logic batch_empty;

    // in_ready_q is only ever high in FILL, so it alone qualifies an accept
    assign accept       = in_valid && in_ready_q;
    assign at_last_byte = (slot_q == LAST_SLOT) && (offset_q == LAST_OFF);
    assign batch_empty  = (slot_q == 2'd0) && (offset_q == FIRST_OFF);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        offset_d    = offset_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        en_write_d  = en_write_q;
        batch_cnt_d = batch_cnt_q;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = {slot_q, offset_q};
                    ram_din_d  = in_data;
                    if (offset_q == LAST_OFF) begin
                        offset_d = 13'd0;
                        slot_d   = slot_q + 2'd1;
                    end else begin
                        offset_d = offset_q + 13'd1;
                    end
                    if (at_last_byte) begin
                        state_d = S_REQ;
                    end else if (flush_req) begin
                        state_d = S_PAD;
                    end
                end else if (flush_req && !batch_empty) begin
                    state_d = S_PAD;
                end
            end
`ifdef LOG_PAGE_SEQ_HDR_EN
            S_HDR: begin
                ram_we_d   = 1'b1;
                ram_addr_d = {2'd0, offset_q};
                case (offset_q[1:0])
                    2'd2:    ram_din_d = batch_cnt_q[15:8];
                    2'd3:    ram_din_d = batch_cnt_q[7:0];
                    default: ram_din_d = 8'h00;
                endcase
                offset_d = offset_q + 13'd1;
                if (offset_q[1:0] == 2'd3) begin
                    state_d = S_FILL;
                end
            end
`endif
            S_PAD: begin
                ram_we_d   = 1'b1;
                ram_addr_d = {slot_q, offset_q};
                ram_din_d  = PAD_BYTE;
                if (offset_q == LAST_OFF) begin
                    offset_d = 13'd0;
                    slot_d   = slot_q + 2'd1;
                end else begin
                    offset_d = offset_q + 13'd1;
                end
                if (at_last_byte) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                en_write_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (end_write) begin
                    en_write_d  = 1'b0;
                    slot_d      = 2'd0;
                    offset_d    = 13'd0;
                    batch_cnt_d = batch_cnt_q + 16'd1;
                    state_d     = BATCH_START;
                end
            end
            default: begin
                state_d = BATCH_START;
            end
        endcase

        in_ready_d = (state_d == S_FILL);
        busy_d     = (state_d != S_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BATCH_START;
            slot_q      <= 2'd0;
            offset_q    <= 13'd0;
            in_ready_q  <= (BATCH_START == S_FILL);
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 15'd0;
            ram_din_q   <= 8'd0;
            en_write_q  <= 1'b0;
            busy_q      <= (BATCH_START != S_FILL);
            batch_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            offset_q    <= offset_d;
            in_ready_q  <= in_ready_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            en_write_q  <= en_write_d;
            busy_q      <= busy_d;
            batch_cnt_q <= batch_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign en_write  = en_write_q;
    assign busy      = busy_q;
    assign batch_cnt = batch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_log_page_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_page_assembler
// Purpose  : Self-checking bench for log_page_assembler (default build).
// Revision : 1.0
// ============================================================================
module tb_log_page_assembler;

    localparam int PB    = 8192;
    localparam int PPW   = 3;
    localparam int TOTAL = PB * PPW;

    localparam int COLLECT = 0;
    localparam int PADDING = 1;
    localparam int REQUEST = 2;
    localparam int AWAIT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush_req = 1'b0;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic        en_write;
    logic        end_write = 1'b0;
    logic        busy;
    logic [15:0] batch_cnt;

    log_page_assembler #(
        .PAGE_BYTES      (PB),
        .PAGES_PER_WRITE (PPW),
        .PAD_BYTE        (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush_req (flush_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .en_write  (en_write),
        .end_write (end_write),
        .busy      (busy),
        .batch_cnt (batch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a linear byte position within the batch plus a phase.
    int          m_phase = COLLECT;
    int          m_pos   = 0;
    logic [15:0] m_batch = 16'd0;
    logic        e_rdy = 1'b1, e_we = 1'b0, e_en = 1'b0, e_busy = 1'b0, m_chk_ad = 1'b1;
    logic [14:0] e_addr = 15'd0;
    logic [7:0]  e_din  = 8'd0;

    function automatic logic [14:0] lin2addr(input int p);
        return 15'(((p / PB) << 13) + (p % PB));
    endfunction

    task automatic put(input logic [7:0] b);
        e_we   = 1'b1;
        e_addr = lin2addr(m_pos);
        e_din  = b;
        m_pos  = m_pos + 1;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                              input logic f, input logic ew);
        e_we = 1'b0;
        if (r) begin
            m_phase = COLLECT; m_pos = 0; m_batch = 16'd0;
            e_addr = 15'd0; e_din = 8'd0; e_en = 1'b0;
        end else begin
            case (m_phase)
                COLLECT: begin
                    if (v) put(d);
                    if (m_pos == TOTAL) m_phase = REQUEST;
                    else if (f && m_pos != 0) m_phase = PADDING;
                end
                PADDING: begin
                    put(8'hFF);
                    if (m_pos == TOTAL) m_phase = REQUEST;
                end
                REQUEST: begin
                    e_en = 1'b1;
                    m_phase = AWAIT;
                end
                default: begin
                    if (ew) begin
                        e_en = 1'b0; m_pos = 0; m_batch = m_batch + 16'd1; m_phase = COLLECT;
                    end
                end
            endcase
        end
        e_rdy    = (m_phase == COLLECT);
        e_busy   = !e_rdy;
        m_chk_ad = e_we || r;
    endtask

    // Apply one cycle of inputs, advance the model, and compare after the edge.
    task automatic tick(input logic r, input logic v, input logic [7:0] d,
                        input logic f, input logic ew);
        rst = r; in_valid = v; in_data = d; flush_req = f; end_write = ew;
        model_step(r, v, d, f, ew);
        @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, ram_we, en_write, busy, batch_cnt} !== {e_rdy, e_we, e_en, e_busy, m_batch} ||
            (m_chk_ad && {ram_addr, ram_din} !== {e_addr, e_din})) begin
            n_errors++;
            $display("FAIL model t=%0t: got rdy=%b we=%b addr=%h din=%h en=%b busy=%b cnt=%0d, required rdy=%b we=%b addr=%h din=%h en=%b busy=%b cnt=%0d",
                     $time, in_ready, ram_we, ram_addr, ram_din, en_write, busy, batch_cnt,
                     e_rdy, e_we, e_addr, e_din, e_en, e_busy, m_batch);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        r, v;
        logic [7:0]  d;
        logic        f, ew;
        logic        x_rdy, x_we;
        logic [14:0] x_addr;
        logic [7:0]  x_din;
        logic        x_en, x_busy, chk_ad;
    } vec_t;

    vec_t vt[12];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int wr_cnt, rdy_cnt, pad_ok, pad_cnt;
        logic [14:0] first_pad;

        // r v d f ew | rdy we addr din en busy chk_ad
        vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0000, 8'hA5, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0001, 8'h3C, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 15'h0002, 8'h7E, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0003, 8'hFF, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 15'h0004, 8'hFF, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0000, 8'h55, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            tick(vt[i].r, vt[i].v, vt[i].d, vt[i].f, vt[i].ew);
            n_checks++;
            if ({in_ready, ram_we, en_write, busy} !== {vt[i].x_rdy, vt[i].x_we, vt[i].x_en, vt[i].x_busy} ||
                (vt[i].chk_ad && {ram_addr, ram_din} !== {vt[i].x_addr, vt[i].x_din})) begin
                n_errors++;
                $display("FAIL vec%0d: got rdy=%b we=%b addr=%h din=%h en=%b busy=%b, required rdy=%b we=%b addr=%h din=%h en=%b busy=%b",
                         i, in_ready, ram_we, ram_addr, ram_din, en_write, busy,
                         vt[i].x_rdy, vt[i].x_we, vt[i].x_addr, vt[i].x_din, vt[i].x_en, vt[i].x_busy);
            end
        end

        // Full batch with data = index
        for (int i = 0; i < TOTAL; i++) begin
            tick(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == PB - 1)     check("slot0_last_addr", 32'(ram_addr), 32'h1FFF);
            if (i == PB)         check("slot1_first_addr", 32'(ram_addr), 32'h2000);
            if (i == 2 * PB)     check("slot2_first_addr", 32'(ram_addr), 32'h4000);
        end
        check("full_last_addr", 32'(ram_addr), 32'h5FFF);
        check("full_last_en", 32'(en_write), 32'h0);
        tick(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        check("full_en_rise", 32'(en_write), 32'h1);
        wr_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 8'(i), (i == 7), 1'b0);
            wr_cnt  += int'(ram_we);
            rdy_cnt += int'(in_ready) + int'(!en_write);
        end
        check("wait_no_writes", 32'(wr_cnt), 32'h0);
        check("wait_held", 32'(rdy_cnt), 32'h0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("end_en_fall", 32'(en_write), 32'h0);
        check("end_rdy", 32'(in_ready), 32'h1);
        check("batch_cnt_1", 32'(batch_cnt), 32'h1);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("stray_end_cnt", 32'(batch_cnt), 32'h1);
        check("stray_end_busy", 32'(busy), 32'h0);

        // Flush after 10 bytes
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        pad_cnt = 0; pad_ok = 1; first_pad = 15'h7FFF;
        for (int k = 0; k < TOTAL + 16 && !en_write; k++) begin
            tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            if (ram_we) begin
                if (pad_cnt == 0) first_pad = ram_addr;
                if (ram_din !== 8'hFF || ram_addr !== lin2addr(10 + pad_cnt)) pad_ok = 0;
                pad_cnt++;
            end
        end
        check("flush_en_reached", 32'(en_write), 32'h1);
        check("flush_pad_count", 32'(pad_cnt), 32'd24566);
        check("flush_first_addr", 32'(first_pad), 32'h000A);
        check("flush_pad_seq", 32'(pad_ok), 32'h1);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("batch_cnt_2", 32'(batch_cnt), 32'h2);

        // Empty flush right after reset
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        wr_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            wr_cnt += int'(ram_we) + int'(en_write);
        end
        check("empty_flush_quiet", 32'(wr_cnt), 32'h0);

        // Reset mid-batch
        for (int i = 0; i < 5000; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check("midrst_outputs", 32'({in_ready, ram_we, ram_addr, ram_din, en_write, busy}),
              32'({1'b1, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0}));
        check("midrst_cnt", 32'(batch_cnt), 32'h0);
        tick(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        check("midrst_next_addr", 32'(ram_addr), 32'h0000);
        check("midrst_next_din", 32'(ram_din), 32'hC3);

        // Randomized batch against the model
        for (int i = 0; i < 3000 && m_phase == COLLECT; i++)
            tick(1'b0, ($urandom_range(99) < 70), 8'($urandom),
                 ($urandom_range(1999) == 0), ($urandom_range(49) == 0));
        if (m_phase == COLLECT) tick(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < TOTAL + 16 && m_phase != AWAIT; k++)
            tick(1'b0, ($urandom_range(1) == 1), 8'($urandom), ($urandom_range(99) == 0), 1'b0);
        check("rand_reached_wait", 32'(en_write), 32'h1);
        for (int i = 0; i < int'($urandom_range(20)); i++)
            tick(1'b0, ($urandom_range(1) == 1), 8'($urandom), ($urandom_range(3) == 0), 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("rand_batch_cnt", 32'(batch_cnt), 32'h1);
        for (int i = 0; i < 50; i++)
            tick(1'b0, ($urandom_range(1) == 1), 8'($urandom), 1'b0, ($urandom_range(9) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
